// File: rtl/mem_block_writer.sv
// mem_block_writer: packs a scalar word stream into memory blocks of up to
// BLOCK_SIZE words. Each block goes out as one registered, single-cycle write.
// The lowest address of a block sits in the most significant slot of o_data_w.
module mem_block_writer #(
    parameter int SIZE       = 32,
    parameter int BLOCK_SIZE = 5,
    parameter int ADDR_SIZE  = 24,
    parameter int LEN_W      = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_cmd_valid,
    output logic                               o_cmd_ready,
    input  logic [ADDR_SIZE-1:0]               i_cmd_addr,
    input  logic [LEN_W-1:0]                   i_cmd_len,
    input  logic                               i_data_valid,
    output logic                               o_data_ready,
    input  logic [SIZE-1:0]                    i_data,
    output logic                               o_wr_en,
    output logic [ADDR_SIZE-1:0]               o_addr_w,
    output logic [BLOCK_SIZE-1:0][SIZE-1:0]    o_data_w,
    output logic [$clog2(BLOCK_SIZE)-1:0]      o_wr_size,
    output logic                               o_busy,
    output logic                               o_done
);

    localparam int SLOT_W = $clog2(BLOCK_SIZE);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                          state;
    state_t                          state_nxt;
    logic [ADDR_SIZE-1:0]            run_addr;
    logic [LEN_W-1:0]                remaining;
    logic [SLOT_W-1:0]               slot_cnt;
    logic [BLOCK_SIZE-1:0][SIZE-1:0] pack_buf;
    logic [BLOCK_SIZE-1:0][SIZE-1:0] pack_fill;
    logic                            cmd_fire;
    logic                            data_fire;
    logic                            last_word;
    logic                            blk_close;
    logic                            zero_cmd;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a non-empty command starts filling, closing the last block ends it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire && (i_cmd_len != '0)) state_nxt = FILL;
            FILL:    if (blk_close && last_word)        state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake decode and block-close conditions for the current cycle.
    always_comb begin
        cmd_fire  = i_cmd_valid && o_cmd_ready && (state == IDLE);
        data_fire = i_data_valid && o_data_ready && (state == FILL);
        last_word = (remaining == LEN_W'(1));
        blk_close = data_fire && (last_word || (slot_cnt == SLOT_W'(BLOCK_SIZE - 1)));
        zero_cmd  = cmd_fire && (i_cmd_len == '0);
    end

    // Buffer image with the incoming word dropped into slot BLOCK_SIZE-1-slot_cnt.
    always_comb begin
        pack_fill = pack_buf;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (slot_cnt == SLOT_W'(BLOCK_SIZE - 1 - i)) pack_fill[i] = i_data;
        end
    end

    // Registered handshake and status outputs follow the upcoming state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cmd_ready  <= 1'b0;
            o_data_ready <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_cmd_ready  <= (state_nxt == IDLE);
            o_data_ready <= (state_nxt == FILL);
            o_busy       <= (state_nxt == FILL);
            o_done       <= zero_cmd || (blk_close && last_word);
        end
    end

    // Packing datapath: the buffer is cleared on every close so unused slots go out as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_addr  <= '0;
            remaining <= '0;
            slot_cnt  <= '0;
            pack_buf  <= '0;
            o_wr_en   <= 1'b0;
            o_addr_w  <= '0;
            o_data_w  <= '0;
            o_wr_size <= '0;
        end else begin
            o_wr_en <= blk_close;
            if (cmd_fire) begin
                run_addr  <= i_cmd_addr;
                remaining <= i_cmd_len;
                slot_cnt  <= '0;
                pack_buf  <= '0;
            end else if (data_fire) begin
                remaining <= remaining - LEN_W'(1);
                if (blk_close) begin
                    o_data_w  <= pack_fill;
                    o_wr_size <= slot_cnt + SLOT_W'(1);
                    o_addr_w  <= run_addr;
                    run_addr  <= run_addr + ADDR_SIZE'(slot_cnt) + ADDR_SIZE'(1);
                    slot_cnt  <= '0;
                    pack_buf  <= '0;
                end else begin
                    pack_buf <= pack_fill;
                    slot_cnt <= slot_cnt + SLOT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_block_writer.sv
// tb_mem_block_writer: drives randomized transfers into mem_block_writer and
// compares every block write and done pulse against a transfer-level model.
module tb_mem_block_writer;

    localparam int BS = 5;

    logic                 clk;
    logic                 i_rst_n;
    logic                 i_cmd_valid;
    logic                 o_cmd_ready;
    logic [23:0]          i_cmd_addr;
    logic [15:0]          i_cmd_len;
    logic                 i_data_valid;
    logic                 o_data_ready;
    logic [31:0]          i_data;
    logic                 o_wr_en;
    logic [23:0]          o_addr_w;
    logic [BS-1:0][31:0]  o_data_w;
    logic [2:0]           o_wr_size;
    logic                 o_busy;
    logic                 o_done;

    typedef struct packed {
        logic [31:0]         cyc;
        logic [23:0]         addr;
        logic [2:0]          size;
        logic [BS-1:0][31:0] data;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    int          done_q[$];
    logic [31:0] words_q[$];
    int          acc_q[$];
    int          cyc;
    int          cmd_cyc;
    int          exp_done;
    bit          timeout;
    bit          busy_seen;
    int          vectors;
    int          miscompares;

    mem_block_writer #(
        .SIZE(32), .BLOCK_SIZE(BS), .ADDR_SIZE(24), .LEN_W(16)
    ) dut (
        .i_clk(clk),
        .i_rst_n(i_rst_n),
        .i_cmd_valid(i_cmd_valid),
        .o_cmd_ready(o_cmd_ready),
        .i_cmd_addr(i_cmd_addr),
        .i_cmd_len(i_cmd_len),
        .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready),
        .i_data(i_data),
        .o_wr_en(o_wr_en),
        .o_addr_w(o_addr_w),
        .o_data_w(o_data_w),
        .o_wr_size(o_wr_size),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Advance to the next falling edge and record what the DUT shows there.
    task automatic tick();
        wr_t rec;
        @(negedge clk);
        if (o_wr_en === 1'b1) begin
            rec.cyc  = cyc;
            rec.addr = o_addr_w;
            rec.size = o_wr_size;
            rec.data = o_data_w;
            obs_q.push_back(rec);
        end
        if (o_done === 1'b1) done_q.push_back(cyc);
        if (o_busy === 1'b1) busy_seen = 1'b1;
    endtask

    // Issue one command and stream its words; gap_pct sets the chance of an idle cycle.
    task automatic run_transfer(input logic [23:0] base, input int len, input int gap_pct,
                                input bit counting);
        int idx;
        int budget;
        words_q.delete(); acc_q.delete(); obs_q.delete(); done_q.delete();
        busy_seen = 1'b0;
        timeout   = 1'b0;
        for (int i = 0; i < len; i++) words_q.push_back(counting ? 32'(i + 1) : $urandom);
        budget = 0;
        while (o_cmd_ready !== 1'b1 && budget < 50) begin tick(); budget++; end
        if (o_cmd_ready !== 1'b1) timeout = 1'b1;
        i_cmd_valid  = 1'b1;
        i_cmd_addr   = base;
        i_cmd_len    = 16'(len);
        i_data_valid = (gap_pct > 0);
        i_data       = $urandom;
        cmd_cyc      = cyc;
        tick();
        i_cmd_valid = 1'b0;
        idx    = 0;
        budget = 0;
        while (idx < len && budget < 400) begin
            i_data_valid = (int'($urandom_range(0, 99)) >= gap_pct);
            i_data       = i_data_valid ? words_q[idx] : $urandom;
            if (gap_pct > 0) begin
                i_cmd_valid = 1'($urandom_range(0, 1));
                i_cmd_addr  = 24'($urandom);
                i_cmd_len   = 16'($urandom);
            end
            if (i_data_valid && o_data_ready === 1'b1) begin
                acc_q.push_back(cyc);
                idx++;
            end
            tick();
            budget++;
        end
        i_data_valid = 1'b0;
        i_cmd_valid  = 1'b0;
        if (idx < len) timeout = 1'b1;
        budget = 0;
        while (done_q.size() == 0 && budget < 8) begin tick(); budget++; end
    endtask

    // Transfer-level model: blocks of BS words, addresses wrap at 24 bits, write one cycle after the closing word.
    function automatic void build_expected(input logic [23:0] base, input int len);
        wr_t rec;
        int  n;
        exp_q.delete();
        for (int first = 0; first < len; first += BS) begin
            n        = (len - first < BS) ? len - first : BS;
            rec.addr = base + 24'(first);
            rec.size = 3'(n);
            rec.data = '0;
            for (int s = 0; s < n; s++) rec.data[BS-1-s] = words_q[first+s];
            rec.cyc  = (first + n - 1 < acc_q.size()) ? 32'(acc_q[first+n-1] + 1) : 32'hFFFF_FFFF;
            exp_q.push_back(rec);
        end
        if (len == 0) exp_done = cmd_cyc + 1;
        else          exp_done = (acc_q.size() == len) ? acc_q[len-1] + 1 : -1;
    endfunction

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick(); tick();
        vectors++;
        if ({o_cmd_ready, o_data_ready, o_wr_en, o_addr_w, o_data_w, o_wr_size, o_busy, o_done} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got ready=%b dready=%b wr=%b addr=%h size=%h busy=%b done=%b, want all 0",
                     o_cmd_ready, o_data_ready, o_wr_en, o_addr_w, o_wr_size, o_busy, o_done);
        end
        i_rst_n = 1'b1;
        #1;
        vectors++;
        if (o_cmd_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release_ready: got %b, want 0", o_cmd_ready);
        end
        tick();
        vectors++;
        if ({o_cmd_ready, o_data_ready, o_busy} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_first_edge: got cmd_ready/data_ready/busy=%b, want 100",
                     {o_cmd_ready, o_data_ready, o_busy});
        end
    endtask

    task automatic test_two_full_blocks();
        run_transfer(24'h000010, 10, 0, 1'b1);
        build_expected(24'h000010, 10);
        vectors++;
        if (timeout || obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL two_blocks_count: got %0d writes (timeout=%b), want %0d", obs_q.size(), timeout, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL two_blocks_write%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != exp_done) begin
            miscompares++;
            $display("[TB] FAIL two_blocks_done: got %0d pulses first@%0d, want 1 @%0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, exp_done);
        end
        vectors++;
        if (acc_q.size() != 10 || acc_q[0] != cmd_cyc + 1 || acc_q[9] != cmd_cyc + 10) begin
            miscompares++;
            $display("[TB] FAIL two_blocks_bubbles: got %0d words over cycles, want 10 back-to-back from %0d",
                     acc_q.size(), cmd_cyc + 1);
        end
        vectors++;
        if ({o_busy, o_cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL two_blocks_end_status: got busy/cmd_ready=%b, want 01", {o_busy, o_cmd_ready});
        end
    endtask

    task automatic test_partial_block();
        run_transfer(24'h000100, 7, 0, 1'b0);
        build_expected(24'h000100, 7);
        vectors++;
        if (timeout || obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL partial_count: got %0d writes (timeout=%b), want %0d", obs_q.size(), timeout, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL partial_write%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != exp_done) begin
            miscompares++;
            $display("[TB] FAIL partial_done: got %0d pulses, want 1 @%0d", done_q.size(), exp_done);
        end
    endtask

    task automatic test_zero_length();
        run_transfer(24'h123456, 0, 30, 1'b0);
        build_expected(24'h123456, 0);
        vectors++;
        if (timeout || obs_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL zero_len_writes: got %0d writes (timeout=%b), want 0", obs_q.size(), timeout);
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != exp_done) begin
            miscompares++;
            $display("[TB] FAIL zero_len_done: got %0d pulses, want 1 @%0d", done_q.size(), exp_done);
        end
        tick(); tick();
        vectors++;
        if (busy_seen || o_cmd_ready !== 1'b1 || done_q.size() != 1 || obs_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL zero_len_idle: got busy_seen=%b cmd_ready=%b dones=%0d writes=%0d, want 0 1 1 0",
                     busy_seen, o_cmd_ready, done_q.size(), obs_q.size());
        end
    endtask

    task automatic test_wrap_stall();
        run_transfer(24'hFFFFFD, 6, 40, 1'b0);
        build_expected(24'hFFFFFD, 6);
        vectors++;
        if (timeout || obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("[TB] FAIL wrap_count: got %0d writes (timeout=%b), want %0d", obs_q.size(), timeout, exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("[TB] FAIL wrap_write%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            end
        end
        vectors++;
        if (done_q.size() != 1 || done_q[0] != exp_done) begin
            miscompares++;
            $display("[TB] FAIL wrap_done: got %0d pulses, want 1 @%0d", done_q.size(), exp_done);
        end
    endtask

    task automatic test_abort();
        int cnt;
        int budget;
        obs_q.delete(); done_q.delete();
        budget = 0;
        while (o_cmd_ready !== 1'b1 && budget < 50) begin tick(); budget++; end
        i_cmd_valid = 1'b1;
        i_cmd_addr  = 24'h000040;
        i_cmd_len   = 16'd8;
        tick();
        i_cmd_valid = 1'b0;
        cnt    = 0;
        budget = 0;
        while (cnt < 3 && budget < 50) begin
            i_data_valid = 1'b1;
            i_data       = $urandom;
            if (o_data_ready === 1'b1) cnt++;
            tick();
            budget++;
        end
        i_data_valid = 1'b0;
        vectors++;
        if (cnt != 3 || o_busy !== 1'b1 || o_data_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL abort_midway: got words=%0d busy=%b data_ready=%b, want 3 1 1", cnt, o_busy, o_data_ready);
        end
        #2 i_rst_n = 1'b0;
        #1;
        vectors++;
        if ({o_cmd_ready, o_data_ready, o_wr_en, o_addr_w, o_data_w, o_wr_size, o_busy, o_done} !== '0) begin
            miscompares++;
            $display("[TB] FAIL abort_async_reset: got ready=%b dready=%b wr=%b addr=%h size=%h busy=%b done=%b, want all 0",
                     o_cmd_ready, o_data_ready, o_wr_en, o_addr_w, o_wr_size, o_busy, o_done);
        end
        tick(); tick(); tick();
        i_rst_n = 1'b1;
        tick(); tick();
        vectors++;
        if (obs_q.size() != 0 || done_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_write: got %0d writes %0d dones, want 0 0", obs_q.size(), done_q.size());
        end
        run_transfer(24'h000000, 1, 0, 1'b0);
        build_expected(24'h000000, 1);
        vectors++;
        if (timeout || obs_q.size() != 1) begin
            miscompares++;
            $display("[TB] FAIL abort_next_count: got %0d writes (timeout=%b), want 1", obs_q.size(), timeout);
        end else begin
            vectors++;
            if (obs_q[0] !== exp_q[0]) begin
                miscompares++;
                $display("[TB] FAIL abort_next_write: got %h, want %h", obs_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          prev_done;
        int          len;
        int          gap;
        logic [23:0] base;
        prev_done = -1;
        for (int t = 0; t < 8; t++) begin
            len  = int'($urandom_range(1, 13));
            gap  = (t % 2 == 0) ? 0 : 30;
            base = 24'($urandom);
            run_transfer(base, len, gap, 1'b0);
            build_expected(base, len);
            vectors++;
            if (timeout || obs_q.size() != exp_q.size()) begin
                miscompares++;
                $display("[TB] FAIL b2b%0d_count: got %0d writes (timeout=%b), want %0d", t, obs_q.size(), timeout, exp_q.size());
            end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin
                    miscompares++;
                    $display("[TB] FAIL b2b%0d_write%0d: got %h, want %h", t, i, obs_q[i], exp_q[i]);
                end
            end
            vectors++;
            if (done_q.size() != 1 || done_q[0] != exp_done) begin
                miscompares++;
                $display("[TB] FAIL b2b%0d_done: got %0d pulses, want 1 @%0d", t, done_q.size(), exp_done);
            end
            if (prev_done >= 0) begin
                vectors++;
                if (cmd_cyc != prev_done) begin
                    miscompares++;
                    $display("[TB] FAIL b2b%0d_cmd_in_done_cycle: got accept @%0d, want @%0d", t, cmd_cyc, prev_done);
                end
            end
            if (gap == 0) begin
                vectors++;
                if (acc_q.size() == 0 || acc_q[0] != cmd_cyc + 1) begin
                    miscompares++;
                    $display("[TB] FAIL b2b%0d_first_word: got %0d words first@%0d, want first @%0d",
                             t, acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : -1, cmd_cyc + 1);
                end
            end
            prev_done = (done_q.size() > 0) ? done_q[0] : -1;
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        cyc          = 0;
        i_rst_n      = 1'b0;
        i_cmd_valid  = 1'b0;
        i_cmd_addr   = '0;
        i_cmd_len    = '0;
        i_data_valid = 1'b0;
        i_data       = '0;
        test_reset();
        test_two_full_blocks();
        test_partial_block();
        test_zero_length();
        test_wrap_stall();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_block_writer.md
# mem_block_writer

Upstream write-packing stage for the block memory. It accepts a transfer command (base word address, length in words) and then a scalar word stream over a valid/ready handshake. It packs the words into blocks of up to BLOCK_SIZE and issues one single-cycle block write per block on the memory write port. A partial final block is written with a reduced write size.

## Interface
- SIZE, 32, word width in bits
- BLOCK_SIZE, 5, words per memory block write; must not be a power of two, so the full count fits in $clog2(BLOCK_SIZE) bits
- ADDR_SIZE, 24, memory word-address width
- LEN_W, 16, transfer length counter width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when valid && ready
- i_cmd_addr  in  ADDR_SIZE  base word address of the transfer
- i_cmd_len  in  LEN_W  transfer length in words
- i_data_valid  in  1  stream word valid
- o_data_ready  out  1  stream word accepted when valid && ready
- i_data  in  SIZE  stream word
- o_wr_en  out  1  memory write strobe, one cycle per block
- o_addr_w  out  ADDR_SIZE  block base address
- o_data_w  out  BLOCK_SIZE×SIZE, packed as [BLOCK_SIZE-1:0][SIZE-1:0]  block data
- o_wr_size  out  $clog2(BLOCK_SIZE)  number of valid words in the block, 1..BLOCK_SIZE
- o_busy  out  1  a transfer is in progress
- o_done  out  1  one-cycle pulse marking transfer completion

## Operation
- The state machine has two states, IDLE and FILL.
- **IDLE**
  - o_cmd_ready=1 and o_data_ready=0.
  - Accepting a command latches the base address into the running address, loads the remaining count with i_cmd_len, and clears the slot count.
  - If len≠0, the next state is FILL, and o_cmd_ready and o_busy switch (0 and 1) on the next cycle.
  - If len=0, o_done pulses on the next cycle, no write is issued, and the block stays in IDLE.
- **FILL**
  - o_data_ready=1 and o_cmd_ready=0. Commands are not accepted.
  - Each accepted word goes into slot k (k = slot count) of the packing buffer, and remaining decrements.
  - **Slot ordering:** the word for address base+k is placed at o_data_w[BLOCK_SIZE-1-k], so the lowest address sits in the MSB slot, matching the memory port.
- **Block close:** a block closes when the accepted word fills slot BLOCK_SIZE-1, or when it is the last word of the transfer (remaining becomes 0).
  - On close, the buffer is copied into the output registers, with unused slots zero-filled.
  - o_wr_size = the number of words in the block; o_addr_w = the running address.
  - The running address advances by o_wr_size, modulo 2^ADDR_SIZE (wrap-around is silent).
  - The slot count clears in the same cycle, so packing continues without a bubble.
- **End of transfer:** closing the last block returns the machine to IDLE.
- o_wr_en, o_addr_w, o_data_w and o_wr_size are registered. o_data_w and o_wr_size hold their values between writes; o_wr_en is a pulse.
- The memory write port never stalls, so no back-pressure from memory is modelled.

## Timing
- **Reset values:**
  - o_cmd_ready=0; it rises on the first clock edge after reset release.
  - o_data_ready=0, o_wr_en=0, o_addr_w=0, o_data_w=0, o_wr_size=0, o_busy=0, o_done=0.
  - Internal state is IDLE and all counters are 0.
- **Throughput:** one word per cycle sustained in FILL. Gaps in i_data_valid only stall the transfer.
- **Write latency:** if the word closing a block is accepted at edge t, then o_wr_en=1 in the cycle after t with the block contents.
- **Completion:** o_done=1 in the same cycle as the final block's o_wr_en. o_busy falls and o_cmd_ready rises in that same cycle.
  - The next command can be accepted in that cycle. Its first data word can be accepted one cycle later.
- **Reset mid-transfer:** the partial block is discarded, and no write or done pulse is emitted. Outputs return to their reset values immediately (asynchronous reset).
- **Ignored inputs:** i_data_valid is ignored in IDLE, and i_cmd_valid is ignored in FILL.

## Test plan
- **Reset:** assert i_rst_n=0 mid-cycle -> all outputs are 0 immediately; o_cmd_ready=1 one edge after release.
- **Two full blocks:** cmd addr=0x10, len=10, with words 1..10 streamed back-to-back -> two writes.
  - Write 1: addr 0x10, size 5, o_data_w[4..0]=1,2,3,4,5.
  - Write 2: addr 0x15, size 5, data 6..10.
  - o_done coincides with write 2, and there are no bubbles.
- **Partial block:** cmd addr=0x100, len=7 -> write addr 0x100 size 5, then write addr 0x105 size 2 with o_data_w[4]=w6, o_data_w[3]=w7 and slots 2..0 = 0.
- **Zero length:** cmd len=0 -> o_done pulse one cycle later, no o_wr_en, and o_busy stays 0.
- **Wrap-around and stalls:** cmd addr=2^24-3, len=6, with random i_data_valid gaps -> writes at addr 0xFFFFFD size 5 and 0x000002 size 1. Data order is preserved regardless of gaps.
- **Abort:** reset after 3 of 8 words have been accepted -> no write issued. A subsequent cmd addr=0, len=1 produces a single write of size 1.
